// File: rtl/ecc_lock_pkg.sv
// Shared definitions for the key-locked SECDED pipeline: default geometry,
// data-bit to codeword-position mapping and syndrome classes.
package ecc_lock_pkg;

    localparam int          DEF_DATA_W      = 32;
    localparam int          DEF_CHK_W       = 7;
    localparam int          DEF_KEY_W       = 32;
    localparam logic [31:0] DEF_CORRECT_KEY = 32'hA5C3_0F96;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } syn_class_e;

    // Data bit idx lands on the (idx+1)-th non-power-of-two position; every
    // power-of-two slot at or below the running position pushes it up by one.
    function automatic int data_pos(input int idx);
        int pos;
        pos = idx + 1;
        for (int j = 0; j < 8; j++) begin
            if (pos >= (1 << j)) begin
                pos = pos + 1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received word.
module secded_syndrome
    import ecc_lock_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CHK_W  = DEF_CHK_W
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [CHK_W-1:0]  chk_i,
    output logic [CHK_W-2:0]  syn_o,
    output logic              par_o
);

    localparam int SW = CHK_W - 1;

    // The MSB of chk_i is the overall parity bit and has no codeword position.
    always_comb begin
        syn_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data_i[i]) begin
                syn_o = syn_o ^ SW'(data_pos(i));
            end
        end
        for (int j = 0; j < SW; j++) begin
            if (chk_i[j]) begin
                syn_o = syn_o ^ SW'(1 << j);
            end
        end
        par_o = ^{data_i, chk_i};
    end

endmodule

// File: rtl/locked_secded_pipe.sv
// Two-stage SECDED decoder whose corrected output is XOR-masked unless the
// serially loaded key matches CORRECT_KEY.
module locked_secded_pipe
    import ecc_lock_pkg::*;
#(
    parameter int               DATA_W      = DEF_DATA_W,
    parameter int               CHK_W       = DEF_CHK_W,
    parameter int               KEY_W       = DEF_KEY_W,
    parameter logic [KEY_W-1:0] CORRECT_KEY = KEY_W'(DEF_CORRECT_KEY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_single,
    output logic              out_err_double,
    input  logic              key_load,
    input  logic              key_bit,
    output logic              key_loaded
);

    localparam int SW     = CHK_W - 1;
    localparam int CW_LEN = DATA_W + CHK_W - 1;
    localparam int CNT_W  = $clog2(KEY_W + 1);

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [SW-1:0]     s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              err_single_q, err_single_d;
    logic              err_double_q, err_double_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [SW-1:0]     syn_w;
    logic              par_w;
    logic              s1_adv, s2_adv, accept;
    logic [DATA_W-1:0] corr_data, mask;
    logic [KEY_W-1:0]  key_x;
    syn_class_e        cls;

    secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
        .data_i (in_data),
        .chk_i  (in_chk),
        .syn_o  (syn_w),
        .par_o  (par_w)
    );

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = !key_load && s1_adv;
    assign accept   = in_valid && in_ready;

    // Only a data position can match the syndrome, so check-bit, zero and
    // out-of-range syndromes leave the data untouched.
    always_comb begin
        corr_data = s1_data_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (s1_par_q && (s1_syn_q == SW'(data_pos(i)))) begin
                corr_data[i] = ~s1_data_q[i];
            end
        end
        if (s1_syn_q == '0 && !s1_par_q) begin
            cls = CLEAN;
        end else if (s1_par_q && ((s1_syn_q & (s1_syn_q - SW'(1))) == '0)) begin
            cls = SINGLE;
        end else if (s1_par_q && (int'(s1_syn_q) <= CW_LEN)) begin
            cls = SINGLE;
        end else begin
            cls = DOUBLE;
        end
        key_x = key_q ^ CORRECT_KEY;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = key_x[i % KEY_W];
        end
    end

    always_comb begin
        s1_vld_d     = s1_vld_q;
        s1_data_d    = s1_data_q;
        s1_syn_d     = s1_syn_q;
        s1_par_d     = s1_par_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        err_single_d = err_single_q;
        err_double_d = err_double_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        if (s1_adv) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_data_d = in_data;
                s1_syn_d  = syn_w;
                s1_par_d  = par_w;
            end
        end
        if (s2_adv) begin
            out_valid_d = s1_vld_q;
            if (s1_vld_q) begin
                out_data_d   = corr_data ^ mask;
                err_single_d = (cls == SINGLE);
                err_double_d = (cls == DOUBLE);
            end
        end
        if (key_load) begin
            key_d = {key_q[KEY_W-2:0], key_bit};
            if (cnt_q != CNT_W'(KEY_W)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            key_q        <= '0;
            cnt_q        <= '0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_single_q <= err_single_d;
            err_double_q <= err_double_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
        end
    end

    // Stage-1 payload is qualified by s1_vld_q and needs no reset.
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_err_single = err_single_q;
    assign out_err_double = err_double_q;
    assign key_loaded     = (cnt_q == CNT_W'(KEY_W));

endmodule

// File: tb/tb_locked_secded_pipe.sv
// Directed bench for locked_secded_pipe with a codeword-level reference model.
module tb_locked_secded_pipe;

    localparam int DW   = 32;
    localparam int CW   = 7;
    localparam int KW   = 32;
    localparam int NPOS = DW + CW - 1;
    localparam logic [KW-1:0] KEY = 32'hA5C3_0F96;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_chk = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_err_single, out_err_double;
    logic          key_load = 1'b0;
    logic          key_bit = 1'b0;
    logic          key_loaded;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } word_t;

    word_t         q[$];
    logic [KW-1:0] key_m = '0;
    int            kcnt_m = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d;
    logic          hold_s, hold_db;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    locked_secded_pipe #(.DATA_W(DW), .CHK_W(CW), .KEY_W(KW), .CORRECT_KEY(KEY)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_chk         (in_chk),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_err_single (out_err_single),
        .out_err_double (out_err_double),
        .key_load       (key_load),
        .key_bit        (key_bit),
        .key_loaded     (key_loaded)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Builds the codeword explicitly, decodes it position by position, then masks.
    function automatic void model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                  input logic [KW-1:0] k, output logic [DW-1:0] od,
                                  output logic os, output logic odb);
        logic          cwd [1:NPOS];
        logic [DW-1:0] dd;
        int            di, ci, s;
        logic          p;
        di = 0; ci = 0; s = 0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) == 0) begin
                cwd[pos] = c[ci];
                ci++;
            end else begin
                cwd[pos] = d[di];
                di++;
            end
            if (cwd[pos]) s = s ^ pos;
        end
        p = (^d) ^ (^c);
        os = 1'b0;
        odb = 1'b0;
        if (p) begin
            if (s == 0 || (s & (s - 1)) == 0) begin
                os = 1'b1;
            end else if (s <= NPOS) begin
                cwd[s] = ~cwd[s];
                os = 1'b1;
            end else begin
                odb = 1'b1;
            end
        end else if (s != 0) begin
            odb = 1'b1;
        end
        di = 0;
        dd = '0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                dd[di] = cwd[pos];
                di++;
            end
        end
        for (int i = 0; i < DW; i++) begin
            od[i] = dd[i] ^ k[i % KW] ^ KEY[i % KW];
        end
    endfunction

    initial forever begin
        word_t         w;
        logic [DW-1:0] ed;
        logic          es, edb;
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            key_m = '0;
            kcnt_m = 0;
            hold_v = 1'b0;
        end else begin
            chk("key_loaded", {63'd0, key_loaded}, {63'd0, (kcnt_m >= KW)});
            if (hold_v) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {32'd0, out_data}, {32'd0, hold_d});
                chk("hold_flags", {62'd0, out_err_single, out_err_double}, {62'd0, hold_s, hold_db});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_output: got %h expected no word", out_data);
                end else begin
                    w = q.pop_front();
                    model(w.d, w.c, key_m, ed, es, edb);
                    chk("model_data", {32'd0, out_data}, {32'd0, ed});
                    chk("model_flags", {62'd0, out_err_single, out_err_double}, {62'd0, es, edb});
                end
            end
            hold_v  = out_valid && !out_ready;
            hold_d  = out_data;
            hold_s  = out_err_single;
            hold_db = out_err_double;
            if (in_valid && in_ready) q.push_back('{d: in_data, c: in_chk});
            if (key_load) begin
                key_m = {key_m[KW-2:0], key_bit};
                if (kcnt_m < KW) kcnt_m++;
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int n;
        n = 0;
        in_data  = d;
        in_chk   = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout: in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_check(input string name, input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic [DW-1:0] ed, input logic es, input logic edb);
        send_word(d, c);
        @(negedge clk);
        chk({name, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk({name, "_lat2"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_data"}, {32'd0, out_data}, {32'd0, ed});
        chk({name, "_flags"}, {62'd0, out_err_single, out_err_double}, {62'd0, es, edb});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (q.size() != 0 || out_valid) begin
            nvec++;
            nmis++;
            $display("FAIL drain_timeout: pending=%0d expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [KW-1:0] k);
        for (int i = KW - 1; i >= 0; i--) begin
            key_load = 1'b1;
            key_bit  = k[i];
            @(negedge clk);
            if (i == KW - 1) chk("in_ready_keyload", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        key_load = 1'b0;
    endtask

    initial begin
        int start;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_flags", {62'd0, out_err_single, out_err_double}, 64'd0);
        chk("rst_key_loaded", {63'd0, key_loaded}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        send_check("nokey", 32'h0, 7'h00, 32'hA5C3_0F96, 1'b0, 1'b0);
        chk("nokey_key_loaded", {63'd0, key_loaded}, 64'd0);

        load_key(KEY);
        @(negedge clk);
        chk("key_loaded_after", {63'd0, key_loaded}, 64'd1);
        @(posedge clk);
        #1;

        send_check("zero",       32'h0000_0000, 7'h00, 32'h0000_0000, 1'b0, 1'b0);
        send_check("single_d0",  32'h0000_0001, 7'h00, 32'h0000_0000, 1'b1, 1'b0);
        send_check("double_s6",  32'h0000_0003, 7'h00, 32'h0000_0003, 1'b0, 1'b1);
        send_check("clean_enc",  32'h0000_0001, 7'h43, 32'h0000_0001, 1'b0, 1'b0);
        send_check("fix_d18",    32'h0004_0001, 7'h43, 32'h0000_0001, 1'b1, 1'b0);
        send_check("par_only",   32'h0000_0000, 7'h40, 32'h0000_0000, 1'b1, 1'b0);
        send_check("chk0_err",   32'h0000_0000, 7'h01, 32'h0000_0000, 1'b1, 1'b0);
        send_check("beyond_len", 32'h2004_0001, 7'h00, 32'h2004_0001, 1'b0, 1'b1);

        start = cyc;
        for (int i = 0; i < 6; i++) send_word(32'h1111_1111 * i, CW'(i * 5));
        chk("throughput_cycles", 64'(cyc - start), 64'd6);
        drain();

        out_ready = 1'b0;
        fork
            begin
                send_word(32'hDEAD_0001, 7'h13);
                send_word(32'h0000_00F0, 7'h00);
                send_word(32'h8000_0000, 7'h7F);
                send_word(32'h1234_5678, 7'h2A);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        send_word(32'h0000_0011, 7'h00);
        send_word(32'h0000_0022, 7'h00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_key_loaded", {63'd0, key_loaded}, 64'd0);
        chk("midrst_out_data", {32'd0, out_data}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_check("post_rst", 32'h0000_0001, 7'h43, 32'hA5C3_0F97, 1'b0, 1'b0);
        drain();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
